// File: rtl/lfsr_reg_bank_pkg.sv
// Shared constants, LED mode/direction types and LFSR helpers for lfsr_reg_bank.
package lfsr_reg_bank_pkg;

  // Galois LFSR feedback taps applied when the shifted-out bit is 1.
  localparam logic [31:0] LfsrPoly     = 32'h8020_0003;
  localparam logic [31:0] IdBase       = 32'h1F5B_0000;
  localparam logic [31:0] UnmappedData = 32'hDEAD_BEEF;
  localparam logic [31:0] ResetData    = 32'hFEE1_DEAD;
  // An all-zero LFSR state never leaves zero, so zero seeds become this.
  localparam logic [31:0] SeedFallback = 32'h0000_0001;

  typedef enum logic [1:0] {
    LedStatic = 2'b00,
    LedRotate = 2'b01,
    LedBounce = 2'b10,
    LedHold   = 2'b11
  } led_mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } led_dir_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ ({32{v[0]}} & LfsrPoly);
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return m;
  endfunction

  function automatic logic [31:0] lfsr_seed(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
    logic [31:0] m;
    m = be_merge(old_v, new_v, be);
    return (m == 32'h0) ? SeedFallback : m;
  endfunction

endpackage

// File: rtl/lfsr_reg_bank_led_walker.sv
// LED pattern holder with prescaled rotate/bounce stepping and a registered LED copy.
module led_walker
  import lfsr_reg_bank_pkg::*;
#(
  parameter int unsigned LED_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  led_mode_e        mode,
  input  logic [15:0]      period,
  input  logic             clear,
  input  logic             load,
  input  logic [LED_W-1:0] load_value,
  output logic [LED_W-1:0] pattern,
  output logic [LED_W-1:0] led_out
);

  logic [15:0]      cnt_q, cnt_d;
  logic [LED_W-1:0] pat_q, pat_d;
  led_dir_e         dir_q, dir_d;
  logic             stepping;
  logic             tick;

  // Prescaler, step logic and direction; a load beats a coincident step.
  always_comb begin
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    dir_d    = dir_q;
    tick     = 1'b0;
    stepping = (mode == LedRotate) || (mode == LedBounce);

    if (stepping) begin
      if (cnt_q == period) begin
        cnt_d = 16'h0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'h1;
      end
    end else begin
      cnt_d = 16'h0;
    end

    if (tick) begin
      case (mode)
        LedRotate: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        LedBounce: begin
          if (dir_q == DirUp) begin
            if (pat_q[LED_W-1]) begin
              dir_d = DirDown;
              pat_d = pat_q >> 1;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = DirUp;
              pat_d = pat_q << 1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        default: pat_d = pat_q;
      endcase
    end

    if (clear) begin
      cnt_d = 16'h0;
      dir_d = DirUp;
    end

    if (load) begin
      pat_d = load_value;
      cnt_d = 16'h0;
    end
  end

  // Walker state and the one-cycle LED copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0;
      pat_q <= LED_W'(1);
      dir_q <= DirUp;
      led_out <= '0;
    end else begin
      cnt_q <= cnt_d;
      pat_q <= pat_d;
      dir_q <= dir_d;
      led_out <= pat_q;
    end
  end

  assign pattern = pat_q;

endmodule

// File: rtl/lfsr_reg_bank.sv
// Bus-mapped bank of 32-bit Galois LFSR channels plus an LED walker.
// Optional LFSR_FREERUN_EN: every channel advances each clock instead of on its own reads.
module lfsr_reg_bank
  import lfsr_reg_bank_pkg::*;
#(
  parameter int unsigned NUM_RAND = 4,
  parameter int unsigned LED_W    = 8,
  parameter int unsigned ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  input  logic              ws_n,
  input  logic              rs_n,
  input  logic [3:0]        be,
  input  logic              as,
  output logic [LED_W-1:0]  led_out
);

  localparam int unsigned WordW = ADDR_W - 2;
  localparam logic [WordW-1:0] CtrlWord = WordW'(NUM_RAND);
  localparam logic [WordW-1:0] PatWord  = WordW'(NUM_RAND + 1);
  localparam logic [WordW-1:0] IdWord   = WordW'(NUM_RAND + 2);
  localparam logic [31:0] IdValue = IdBase | (32'(NUM_RAND) << 8) | 32'(LED_W);

  logic [WordW-1:0] word;
  logic             unused_byte_addr;

  logic             busy_q, busy_d;
  logic             accept, rd_acc, wr_acc;

  logic [31:0]      rand_q [NUM_RAND];
  logic [31:0]      rand_d [NUM_RAND];

  led_mode_e        mode_q, mode_d;
  logic [15:0]      period_q, period_d;
  logic             ctrl_wr, pat_wr;
  logic [LED_W-1:0] pat, pat_wdata;

  logic [31:0]      rdata;

  assign word             = address[ADDR_W-1:2];
  assign unused_byte_addr = ^address[1:0];

  // One access per chip-select assertion; read wins when both strobes are low.
  always_comb begin
    accept = as && !busy_q && (!rs_n || !ws_n);
    rd_acc = accept && !rs_n;
    wr_acc = accept && rs_n && !ws_n;
    busy_d = as ? (busy_q | accept) : 1'b0;
  end

  assign ctrl_wr = wr_acc && (word == CtrlWord);
  assign pat_wr  = wr_acc && (word == PatWord);

  // LFSR channel next state: advance on read (or every clock), seed on write.
  always_comb begin
    for (int i = 0; i < NUM_RAND; i++) begin
      rand_d[i] = rand_q[i];
`ifdef LFSR_FREERUN_EN
      rand_d[i] = lfsr_next(rand_q[i]);
`else
      if (rd_acc && (word == WordW'(i))) begin
        rand_d[i] = lfsr_next(rand_q[i]);
      end
`endif
      if (wr_acc && (word == WordW'(i))) begin
        rand_d[i] = lfsr_seed(rand_q[i], data_in, be);
      end
    end
  end

  // LED control: only mode bits and period are stored, merged per byte lane.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    if (ctrl_wr) begin
      mode_d   = led_mode_e'(be[0] ? data_in[1:0] : mode_q);
      period_d = {be[3] ? data_in[31:24] : period_q[15:8],
                  be[2] ? data_in[23:16] : period_q[7:0]};
    end
  end

  // Byte-enable merge of the LED pattern write against the live pattern.
  always_comb begin
    pat_wdata = pat;
    for (int b = 0; b < LED_W; b++) begin
      pat_wdata[b] = be[b/8] ? data_in[b] : pat[b];
    end
  end

  // Read data selection for the addressed word.
  always_comb begin
    rdata = UnmappedData;
    for (int i = 0; i < NUM_RAND; i++) begin
      if (word == WordW'(i)) begin
        rdata = rand_q[i];
      end
    end
    if (word == CtrlWord) rdata = {period_q, 14'h0, mode_q};
    if (word == PatWord)  rdata = 32'(pat);
    if (word == IdWord)   rdata = IdValue;
  end

  // Bus-side state: busy flag, registered read data, LFSR channels, LED control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      data_out <= ResetData;
      for (int i = 0; i < NUM_RAND; i++) begin
        rand_q[i] <= 32'(i + 1);
      end
      mode_q   <= LedStatic;
      period_q <= 16'h0;
    end else begin
      busy_q <= busy_d;
      if (rd_acc) begin
        data_out <= rdata;
      end
      for (int i = 0; i < NUM_RAND; i++) begin
        rand_q[i] <= rand_d[i];
      end
      mode_q   <= mode_d;
      period_q <= period_d;
    end
  end

  led_walker #(
    .LED_W(LED_W)
  ) u_led_walker (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode_q),
    .period     (period_q),
    .clear      (ctrl_wr),
    .load       (pat_wr),
    .load_value (pat_wdata),
    .pattern    (pat),
    .led_out    (led_out)
  );

endmodule

// File: tb/tb_lfsr_reg_bank.sv
// Directed bench for lfsr_reg_bank with default parameters.
module tb_lfsr_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ws_n;
  logic        rs_n;
  logic [3:0]  be;
  logic        as;
  logic [7:0]  led_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] bounce_seq [15] = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20,
                                  8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
  logic [7:0] exp_led;
  int         n;

  lfsr_reg_bank #(
    .NUM_RAND (4),
    .LED_W    (8),
    .ADDR_W   (24)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .ws_n     (ws_n),
    .rs_n     (rs_n),
    .be       (be),
    .as       (as),
    .led_out  (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input int word);
    @(negedge clk);
    address = 24'(word * 4);
    as = 1'b1;
    rs_n = 1'b0;
    @(negedge clk);
    as = 1'b0;
    rs_n = 1'b1;
  endtask

  task automatic bus_write(input int word, input logic [31:0] data, input logic [3:0] b);
    @(negedge clk);
    address = 24'(word * 4);
    data_in = data;
    be = b;
    as = 1'b1;
    ws_n = 1'b0;
    @(negedge clk);
    as = 1'b0;
    ws_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    address = '0;
    data_in = '0;
    ws_n = 1'b1;
    rs_n = 1'b1;
    be = 4'h0;
    as = 1'b0;

    // Reset values
    #12;
    check("rst_data_out", data_out, 32'hFEE1_DEAD);
    check("rst_led_out", 32'(led_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("led_after_rst", 32'(led_out), 32'h1);
    bus_read(5);
    check("pat_rst", data_out, 32'h1);
    bus_read(4);
    check("ctrl_rst", data_out, 32'h0);

    // RAND[0] sequence
    bus_read(0);
    check("rand0_r1", data_out, 32'h0000_0001);
    bus_read(0);
    check("rand0_r2", data_out, 32'h8020_0003);
    bus_read(0);
    check("rand0_r3", data_out, 32'hC030_0002);

    // Two read pulses under one chip select: only the first is accepted
    @(negedge clk);
    address = 24'h0;
    as = 1'b1;
    rs_n = 1'b0;
    @(negedge clk);
    rs_n = 1'b1;
    check("dbl_first", data_out, 32'h6018_0001);
    @(negedge clk);
    rs_n = 1'b0;
    @(negedge clk);
    rs_n = 1'b1;
    check("dbl_hold", data_out, 32'h6018_0001);
    as = 1'b0;
    bus_read(0);
    check("dbl_one_adv", data_out, 32'hB02C_0003);

    // Zero seed substitution and byte-lane merge
    bus_read(1);
    check("rand1_rst", data_out, 32'h0000_0002);
    bus_write(1, 32'h0, 4'hF);
    bus_read(1);
    check("rand1_zero_seed", data_out, 32'h0000_0001);
    bus_write(2, 32'hAABB_CCDD, 4'b0101);
    bus_read(2);
    check("rand2_merge", data_out, 32'h00BB_00DD);

    // ID, write-protected ID, unmapped word
    bus_read(6);
    check("id", data_out, 32'h1F5B_0408);
    bus_write(6, 32'h0, 4'hF);
    bus_read(6);
    check("id_ro", data_out, 32'h1F5B_0408);
    bus_read(40);
    check("unmapped", data_out, 32'hDEAD_BEEF);

    // Rotate-left, period 3: one step every 4 clocks
    bus_write(4, 32'h0003_FFFD, 4'hF);
    n = 0;
    while (led_out !== 8'h02 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("rot_sync", 32'(n < 12), 32'h1);
    exp_led = 8'h02;
    for (int k = 0; k < 8; k++) begin
      repeat (3) @(negedge clk);
      check("rot_hold", 32'(led_out), 32'(exp_led));
      exp_led = {exp_led[6:0], exp_led[7]};
      @(negedge clk);
      check("rot_step", 32'(led_out), 32'(exp_led));
    end
    bus_read(4);
    check("ctrl_rd_mask", data_out, 32'h0003_0001);

    // Bounce, period 0, from a fresh single-bit pattern
    bus_write(4, 32'h0, 4'hF);
    bus_write(5, 32'h1, 4'hF);
    bus_read(5);
    check("pat_rd", data_out, 32'h1);
    bus_write(4, 32'h0000_0002, 4'hF);
    n = 0;
    while (led_out !== 8'h02 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("bnc_sync", 32'(n < 12), 32'h1);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("bnc_step", 32'(led_out), 32'(bounce_seq[k]));
    end

    // Pattern write on a step tick wins, then a zero pattern stays zero
    bus_write(5, 32'h0000_0010, 4'h1);
    @(negedge clk);
    check("pat_write_wins", 32'(led_out), 32'h10);
    bus_write(5, 32'h0, 4'hF);
    repeat (4) @(negedge clk);
    check("pat_zero", 32'(led_out), 32'h0);
    bus_read(5);
    check("pat_zero_rd", data_out, 32'h0);

    // Reset during an access: write is dropped
    @(negedge clk);
    address = 24'h0;
    data_in = 32'h1234_5678;
    be = 4'hF;
    as = 1'b1;
    ws_n = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst2_data_out", data_out, 32'hFEE1_DEAD);
    check("rst2_led_out", 32'(led_out), 32'h0);
    @(negedge clk);
    as = 1'b0;
    ws_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(0);
    check("rst2_rand0", data_out, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
